stage_collision_detector: RTL and testbench

// - Computes per-frame collision flags for one player and drives them straight into

---
 rtl/stage_collision_detector.sv | 150 +++++++++++++++
 tb/tb_stage_collision_detector.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/stage_collision_detector.sv
// Per-frame wall and platform collision flags for one player, computed by a
// multi-cycle scan of a writable platform table and committed once per frame.
module stage_collision_detector #(
  parameter int unsigned        N_PLAT       = 4,
  parameter logic signed [15:0] STAGE_LEFT   = 16'sd0,
  parameter logic signed [15:0] STAGE_RIGHT  = 16'sd640,
  parameter logic signed [15:0] STAGE_BOTTOM = 16'sd40,
  parameter logic signed [15:0] STAGE_TOP    = 16'sd480,
  parameter int unsigned        PLAYER_W     = 32,
  parameter int unsigned        PLAYER_H     = 48,
  parameter int unsigned        LAND_TOL     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame,
  input  logic [31:0] position,
  input  logic        plat_we,
  input  logic [3:0]  plat_addr,
  input  logic [48:0] plat_wdata,
  output logic        wall_Left,
  output logic        wall_Right,
  output logic        wall_Up,
  output logic        wall_Down,
  output logic        platform_Down,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int unsigned IDX_W     = 4;
  localparam int unsigned TBL_DEPTH = 16;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_PLAT - 1);
  localparam logic signed [16:0] W17   = 17'(PLAYER_W);
  localparam logic signed [16:0] H17   = 17'(PLAYER_H);
  localparam logic signed [16:0] TOL17 = 17'(LAND_TOL);

  typedef struct packed {
    logic               valid;
    logic signed [15:0] x_lo;
    logic signed [15:0] x_hi;
    logic signed [15:0] y_top;
  } plat_t;

  typedef enum logic [1:0] {IDLE, WALL, SCAN, COMMIT} state_t;

  state_t             state, state_next;
  plat_t              table_q [TBL_DEPTH];
  logic signed [15:0] px, py;
  logic [IDX_W-1:0]   idx;
  logic               hit, pend;
  logic               t_left, t_right, t_up, t_down;

  plat_t              cur_c;
  logic signed [16:0] px_right_c, py_top_c, land_top_c;
  logic               entry_hit_c;

  // Box edges and the current table entry under test; 17b keeps edges from wrapping.
  assign px_right_c  = 17'(px) + W17;
  assign py_top_c    = 17'(py) + H17;
  assign cur_c       = table_q[idx];
  assign land_top_c  = 17'(cur_c.y_top) + TOL17;
  assign entry_hit_c = cur_c.valid
                    && (cur_c.x_lo < cur_c.x_hi)
                    && (px_right_c > 17'(cur_c.x_lo))
                    && (px < cur_c.x_hi)
                    && (py >= cur_c.y_top)
                    && (17'(py) <= land_top_c);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame) state_next = WALL;
      WALL:    state_next = SCAN;
      SCAN:    if (idx == LAST_IDX) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wall_Left     <= 1'b0;
      wall_Right    <= 1'b0;
      wall_Up       <= 1'b0;
      wall_Down     <= 1'b0;
      platform_Down <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overrun       <= 1'b0;
      pend          <= 1'b0;
      hit           <= 1'b0;
      idx           <= '0;
      px            <= '0;
      py            <= '0;
      t_left        <= 1'b0;
      t_right       <= 1'b0;
      t_up          <= 1'b0;
      t_down        <= 1'b0;
      for (int unsigned i = 0; i < TBL_DEPTH; i++) table_q[i].valid <= 1'b0;
    end else begin
      done <= 1'b0;
      pend <= 1'b0;
      // Table is frozen while a scan is in flight; busy is low in the start cycle.
      if (plat_we && !busy && (32'(plat_addr) < N_PLAT)) table_q[plat_addr] <= plat_wdata;
      case (state)
        IDLE: begin
          if (frame) begin
            px   <= position[31:16];
            py   <= position[15:0];
            busy <= 1'b1;
          end else if (pend) begin
            overrun <= 1'b1;
          end
        end
        WALL: begin
          t_left  <= (px <= STAGE_LEFT);
          t_right <= (px_right_c >= 17'(STAGE_RIGHT));
          t_up    <= (py_top_c >= 17'(STAGE_TOP));
          t_down  <= (py <= STAGE_BOTTOM);
          hit     <= 1'b0;
          idx     <= '0;
          if (frame) overrun <= 1'b1;
        end
        SCAN: begin
          hit <= hit | entry_hit_c;
          idx <= idx + IDX_W'(1);
          if (frame) overrun <= 1'b1;
        end
        COMMIT: begin
          wall_Left     <= t_left;
          wall_Right    <= t_right;
          wall_Up       <= t_up;
          wall_Down     <= t_down;
          platform_Down <= hit;
          done          <= 1'b1;
          busy          <= 1'b0;
          // A frame here gets one more chance in IDLE before counting as an overrun.
          pend          <= frame;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_collision_detector.sv
// Directed bench for stage_collision_detector: a frame-level timeline model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_stage_collision_detector;

  localparam int N = 4;

  logic        clock = 1'b0;
  logic        reset, frame, plat_we;
  logic [31:0] position;
  logic [3:0]  plat_addr;
  logic [48:0] plat_wdata;
  logic        wall_Left, wall_Right, wall_Up, wall_Down, platform_Down;
  logic        busy, done, overrun;
  logic [7:0]  outvec;

  stage_collision_detector dut (
    .clock(clock), .reset(reset), .frame(frame), .position(position),
    .plat_we(plat_we), .plat_addr(plat_addr), .plat_wdata(plat_wdata),
    .wall_Left(wall_Left), .wall_Right(wall_Right), .wall_Up(wall_Up),
    .wall_Down(wall_Down), .platform_Down(platform_Down),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clock = ~clock;

  assign outvec = {wall_Left, wall_Right, wall_Up, wall_Down, platform_Down, busy, done, overrun};

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Frame-level model: flags decided from the table at acceptance, committed N+2 edges later.
  bit       m_val [16];
  int       m_xlo [16], m_xhi [16], m_yt [16];
  logic [4:0] m_flags = '0, m_next = '0;
  bit       m_busy = 0, m_done = 0, m_ovr = 0, m_pend = 0, was_busy;
  int       cyc = 0, m_commit = 0;

  function automatic logic [4:0] expect_flags(input int x, input int y);
    logic [4:0] f;
    f[4] = (x <= 0);
    f[3] = (x + 32 >= 640);
    f[2] = (y + 48 >= 480);
    f[1] = (y <= 40);
    f[0] = 1'b0;
    for (int i = 0; i < N; i++)
      if (m_val[i] && m_xlo[i] < m_xhi[i] && x + 32 > m_xlo[i] && x < m_xhi[i] &&
          y >= m_yt[i] && y <= m_yt[i] + 4)
        f[0] = 1'b1;
    return f;
  endfunction

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      m_flags = '0; m_busy = 0; m_done = 0; m_ovr = 0; m_pend = 0;
      for (int i = 0; i < 16; i++) m_val[i] = 0;
    end else begin
      was_busy = m_busy;
      m_done = 0;
      if (plat_we && !was_busy && int'(plat_addr) < N) begin
        m_val[plat_addr] = plat_wdata[48];
        m_xlo[plat_addr] = int'($signed(plat_wdata[47:32]));
        m_xhi[plat_addr] = int'($signed(plat_wdata[31:16]));
        m_yt[plat_addr]  = int'($signed(plat_wdata[15:0]));
      end
      if (was_busy && cyc == m_commit) begin
        m_flags = m_next; m_done = 1; m_busy = 0; m_pend = frame;
      end else begin
        if (was_busy) begin
          if (frame) m_ovr = 1;
        end else if (frame) begin
          m_next   = expect_flags(int'($signed(position[31:16])), int'($signed(position[15:0])));
          m_commit = cyc + N + 2;
          m_busy   = 1;
        end else if (m_pend) begin
          m_ovr = 1;
        end
        m_pend = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      total++;
      if (outvec !== {m_flags, m_busy, m_done, m_ovr}) begin
        bad++;
        $display("FAIL cycle_cmp cyc=%0d got %b want %b", cyc, outvec, {m_flags, m_busy, m_done, m_ovr});
      end
    end
  end

  task automatic wr(input int a, input bit v, input int xlo, input int xhi, input int yt);
    plat_we = 1'b1; plat_addr = 4'(a);
    plat_wdata = {v, 16'(xlo), 16'(xhi), 16'(yt)};
    @(negedge clock);
    plat_we = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin @(negedge clock); n++; end
  endtask

  task automatic do_frame(input int x, input int y, input logic [4:0] want, input string nm);
    int n;
    position = {16'(x), 16'(y)}; frame = 1'b1;
    @(negedge clock);
    frame = 1'b0;
    wait_done(n);
    chk({nm, "_lat"}, 32'(n), 32'd6);
    chk({nm, "_flags"}, 32'({wall_Left, wall_Right, wall_Up, wall_Down, platform_Down}), 32'(want));
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    @(negedge clock);
    chk({nm, "_done1"}, 32'(done), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, cnt;
    reset = 1'b1; frame = 1'b0; plat_we = 1'b0; position = '0; plat_addr = '0; plat_wdata = '0;
    @(negedge clock); @(negedge clock);
    chk_en = 1'b1;
    chk("reset_outs", 32'(outvec), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    do_frame(100, 200, 5'b00000, "t1");
    do_frame(-10, 40, 5'b10010, "t2");
    do_frame(620, 460, 5'b01100, "t3");

    wr(2, 1'b1, 200, 300, 150);
    wr(5, 1'b1, 0, 600, 100);
    wr(1, 1'b1, 400, 300, 150);
    do_frame(250, 150, 5'b00001, "t4_y150");
    do_frame(250, 154, 5'b00001, "t4_y154");
    do_frame(250, 155, 5'b00000, "t4_y155");
    do_frame(168, 150, 5'b00000, "t4_x168");
    do_frame(169, 150, 5'b00001, "t4_x169");
    do_frame(299, 150, 5'b00001, "t4_x299");
    do_frame(300, 150, 5'b00000, "t4_x300");
    do_frame(250, 100, 5'b00000, "t4_addr5");
    do_frame(420, 150, 5'b00000, "t4_inverted");

    // Second frame and a table write land mid-scan.
    position = {16'd250, 16'd100}; frame = 1'b1;
    @(negedge clock); frame = 1'b0;
    @(negedge clock);
    plat_we = 1'b1; plat_addr = 4'd1; plat_wdata = {1'b1, 16'd0, 16'd600, 16'd100};
    @(negedge clock); plat_we = 1'b0; frame = 1'b1;
    @(negedge clock); frame = 1'b0;
    wait_done(n);
    chk("t5_done_seen", 32'(done), 32'd1);
    chk("t5_flags", 32'(platform_Down), 32'd0);
    chk("t5_overrun", 32'(overrun), 32'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clock); if (done) cnt++; end
    chk("t5_extra_done", 32'(cnt), 32'd0);
    do_frame(250, 100, 5'b00000, "t5_reread");

    do_frame(620, 460, 5'b01100, "t6_pre");
    position = {16'd250, 16'd150}; frame = 1'b1;
    @(negedge clock); frame = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    chk("t6_outs", 32'(outvec), 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clock); if (done) cnt++; end
    chk("t6_no_done", 32'(cnt), 32'd0);
    do_frame(250, 150, 5'b00000, "t6_cleared");
    do_frame(-10, 40, 5'b10010, "t6_after");

    // Frame held through commit starts the next scan without overrun.
    position = {16'd100, 16'd200}; frame = 1'b1;
    @(negedge clock); frame = 1'b0;
    repeat (5) @(negedge clock);
    position = {16'd620, 16'd460}; frame = 1'b1;
    @(negedge clock);
    chk("pa_done", 32'(done), 32'd1);
    chk("pa_flags1", 32'({wall_Left, wall_Right, wall_Up, wall_Down, platform_Down}), 32'd0);
    @(negedge clock); frame = 1'b0;
    chk("pa_busy", 32'(busy), 32'd1);
    wait_done(n);
    chk("pa_lat", 32'(n), 32'd6);
    chk("pa_flags2", 32'({wall_Left, wall_Right, wall_Up, wall_Down, platform_Down}), 32'b01100);
    chk("pa_overrun", 32'(overrun), 32'd0);
    @(negedge clock);

    // Frame only in the commit cycle is dropped and flagged.
    position = {16'hFFF6, 16'd40}; frame = 1'b1;
    @(negedge clock); frame = 1'b0;
    repeat (5) @(negedge clock);
    frame = 1'b1;
    @(negedge clock); frame = 1'b0;
    chk("pb_done", 32'(done), 32'd1);
    chk("pb_flags", 32'({wall_Left, wall_Right, wall_Up, wall_Down, platform_Down}), 32'b10010);
    @(negedge clock);
    chk("pb_overrun", 32'(overrun), 32'd1);
    chk("pb_busy", 32'(busy), 32'd0);

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
